layer_sched: RTL
================

# layer_sched

- Sequencer that runs one full inference through the shared matrix-multiply engine.
- Accepts a scalar input with a start pulse. Issues one engine operation per layer (layer index selects the engine's weight/bias bank) and buffers each layer's activation vector for the next layer.
- Returns element 0 of the final layer with a done pulse.
- Sits between the top-level inference request and the mat_mul engine, replacing ad-hoc layer stepping in the network wrapper.

## Interface
Parameters:
- N, 40, element width in bits (two's complement)
- W, 16, vector length (engine lanes)
- LAYERS, 3, layers per inference (2..4; eng_layer is 2 bits)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  request; accepted only in IDLE
- in_val  in  N  scalar input, sampled on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle result pulse
- out  out  N  final result, held until next accepted start
- err  out  1  sticky protocol error
- eng_start  out  1  one-cycle engine launch pulse
- eng_layer  out  2  layer index / bank select, valid while busy
- eng_vals  out  N x [W]  activation vector, stable from eng_start until eng_done
- eng_done  in  1  engine completion pulse; eng_out valid in the same cycle
- eng_out  in  N x [W]  engine result vector

## Operation
- States and transitions:
  - IDLE: start=1 captures act <= {in_val, 0, ..., 0}, layer <= 0, err <= 0, clears out; next state ISSUE.
  - ISSUE: eng_start=1 for exactly this cycle; next state WAIT unconditionally.
  - WAIT: on eng_done=1, capture the result.
    - If layer < LAYERS-1: act <= eng_out (hidden-layer rule, see Configuration), layer++, next ISSUE.
    - Otherwise: out <= eng_out[0] unmodified, next FIN.
  - FIN: done=1 for one cycle; next IDLE.
- eng_vals is driven from act at all times; eng_layer is driven from layer.
- All outputs are decoded from registers; no combinational path from any input to any output.
- start while busy is ignored, with no effect on in_val, act or layer.
- eng_done in IDLE, ISSUE or FIN sets err and is otherwise ignored; state is unchanged.
- err is cleared only by rst or by an accepted start.
- Arithmetic is pure pass-through; no width change.

## Timing
- Reset values: busy=0, done=0, out=0, err=0, eng_start=0, eng_layer=0, act=all 0, state IDLE.
- Reset mid-operation: the next cycle is IDLE with all reset values. An eng_done arriving later sets err.
- Engine latency L >= 1: eng_done arrives L cycles after eng_start.
- Start accepted in cycle 0:
  - eng_start in cycles 1 + k(L+1), for k = 0..LAYERS-1
  - done in cycle LAYERS(L+1)+1
  - start next accepted in cycle LAYERS(L+1)+2
- eng_start is never asserted twice without an intervening eng_done.

## Configuration
- LAYER_SCHED_RELU_EN
  - Defined: hidden-layer captures clamp each element with bit N-1 set to 0.
  - Undefined: hidden-layer captures are stored raw.
- The final layer is never clamped.

## Structure
- Shared package nn_pkg:
  - N_DEF, W_DEF, LAYERS_DEF
  - typedef act_vec_t (logic [N-1:0] [W])
  - enum sched_state_t {IDLE, ISSUE, WAIT, FIN}
- One sub-module, relu_vec: combinational W-lane clamp, bypassed when LAYER_SCHED_RELU_EN is undefined.

## Test plan
Bench engine model for all scenarios: latency L=4, eng_out[j] = vals[0] - 5 for all j.
- Reset: rst high 2 cycles -> busy=0, done=0, out=0, err=0, eng_start=0, eng_layer=0.
- Nominal, with in_val=10 at cycle 0:
  - eng_start in cycles 1, 6, 11; eng_layer 0, 1, 2
  - done in cycle 16 with out = -5 (40'hFF_FFFF_FFFB)
  - busy drops in cycle 17
- Clamp, with in_val=3:
  - LAYER_SCHED_RELU_EN defined -> out = -5
  - undefined -> out = -12
- start with in_val=99 in cycle 7 of a nominal run -> ignored; still exactly 3 eng_start pulses; out = -5.
- eng_done pulsed in IDLE -> err=1, busy=0. Next start clears err; that run completes normally.
- rst in cycle 8 (layer 1 WAIT) -> cycle 9 all reset values. A fresh start with in_val=10 yields eng_layer 0, 1, 2 and out = -5.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the inference sequencer: default sizes, activation
// vector type and sequencer state encoding.
package nn_pkg;

  localparam int N_DEF      = 40;
  localparam int W_DEF      = 16;
  localparam int LAYERS_DEF = 3;

  typedef logic [W_DEF-1:0][N_DEF-1:0] act_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/layer_sched_if.sv
// Sequencer <-> matrix-multiply engine link. The master launches, the slave
// (engine) completes.
//
// Handshake: eng_start is a one-cycle launch pulse and eng_vals/eng_layer stay
// stable from that pulse until the matching eng_done. eng_done is a one-cycle
// completion pulse with eng_out valid in the same cycle. Only one operation is
// ever outstanding, so there is no ready/backpressure signal.
interface layer_sched_if #(
  parameter int N = 40,
  parameter int W = 16
) ();

  logic                  eng_start;
  logic [1:0]            eng_layer;
  logic [W-1:0][N-1:0]   eng_vals;
  logic                  eng_done;
  logic [W-1:0][N-1:0]   eng_out;

  modport master (
    output eng_start, eng_layer, eng_vals,
    input  eng_done, eng_out
  );

  modport slave (
    input  eng_start, eng_layer, eng_vals,
    output eng_done, eng_out
  );

endinterface

// File: rtl/layer_sched_relu_vec.sv
// W-lane clamp applied to hidden-layer results. Negative lanes become zero
// when LAYER_SCHED_RELU_EN is defined; otherwise the vector passes through.
module relu_vec #(
  parameter int N = 40,
  parameter int W = 16
) (
  input  logic [W-1:0][N-1:0] vals_i,
  output logic [W-1:0][N-1:0] vals_o
);

`ifdef LAYER_SCHED_RELU_EN
  always_comb begin
    vals_o = vals_i;
    for (int j = 0; j < W; j++) begin
      if (vals_i[j][N-1]) vals_o[j] = '0;
    end
  end
`else
  assign vals_o = vals_i;
`endif

endmodule

// File: rtl/layer_sched.sv
// Runs one full inference through the shared engine, one operation per layer.
// Optional hidden-layer clamp: define LAYER_SCHED_RELU_EN.
module layer_sched
  import nn_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int W      = W_DEF,
  parameter int LAYERS = LAYERS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0]        in_val,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        out,
  output logic                err,
  layer_sched_if.master       eng,
  output sched_state_t        state_o
);

  localparam logic [1:0] LAST_LAYER = 2'(LAYERS - 1);

  sched_state_t        state_q, state_d;
  logic [W-1:0][N-1:0] act_q, act_d;
  logic [1:0]          layer_q, layer_d;
  logic [N-1:0]        out_q, out_d;
  logic                err_q, err_d;
  logic [W-1:0][N-1:0] hidden_vals;

  relu_vec #(.N(N), .W(W)) u_relu (
    .vals_i (eng.eng_out),
    .vals_o (hidden_vals)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      layer_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      layer_q <= layer_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    layer_d = layer_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          act_d    = '0;
          act_d[0] = in_val;
          layer_d  = '0;
          out_d    = '0;
          err_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (eng.eng_done) begin
          if (layer_q < LAST_LAYER) begin
            act_d   = hidden_vals;
            layer_d = layer_q + 2'd1;
            state_d = ISSUE;
          end else begin
            out_d   = eng.eng_out[0];
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A completion with nothing outstanding is a protocol error; it wins over
    // the clear from a start accepted in the same cycle.
    if (eng.eng_done && (state_q != WAIT)) err_d = 1'b1;
  end

  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == FIN);
    out           = out_q;
    err           = err_q;
    eng.eng_start = (state_q == ISSUE);
    eng.eng_layer = layer_q;
    eng.eng_vals  = act_q;
    state_o       = state_q;
  end

endmodule
